png_filter: RTL and testbench

//  Per-byte PNG scanline filter stage, directly downstream of the previous-row line fifo.

---
 rtl/png_filter_pkg.sv | 31 +++
 rtl/png_filter_paeth.sv | 37 +++
 rtl/png_filter.sv | 195 +++++++++++++++++++
 tb/tb_png_filter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/png_filter_pkg.sv
// Shared sizes, filter codes and FSM state encodings for the PNG scanline filter.
package png_filter_pkg;

  localparam int SIZE_W_WD = 12;
  localparam int SIZE_H_WD = 12;

  typedef enum logic [2:0] {
    FLT_NONE  = 3'd0,
    FLT_SUB   = 3'd1,
    FLT_UP    = 3'd2,
    FLT_AVG   = 3'd3,
    FLT_PAETH = 3'd4
  } flt_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TYPE = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Unused filter codes 5..7 fall back to None (both for filtering and the type byte).
  function automatic flt_e flt_decode(input logic [2:0] code);
    flt_e t;
    if (code > 3'd4) t = FLT_NONE;
    else             t = flt_e'(code);
    return t;
  endfunction

endpackage

// File: rtl/png_filter_paeth.sv
// Combinational Paeth predictor: chooses a, b or c, whichever is nearest a+b-c.
module png_filter_paeth (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic [7:0] i_c,
  output logic [7:0] o_pred
);

  logic signed [9:0] w_a;
  logic signed [9:0] w_b;
  logic signed [9:0] w_c;
  logic signed [9:0] w_d_bc;
  logic signed [9:0] w_d_ac;
  logic signed [9:0] w_pa;
  logic signed [9:0] w_pb;
  logic signed [9:0] w_pc;

  function automatic logic signed [9:0] abs10(input logic signed [9:0] v);
    return (v < 0) ? -v : v;
  endfunction

  // Distances are taken in 10-bit signed so |a+b-2c| (up to 510) never wraps.
  always_comb begin
    w_a    = signed'({2'b00, i_a});
    w_b    = signed'({2'b00, i_b});
    w_c    = signed'({2'b00, i_c});
    w_d_bc = w_b - w_c;
    w_d_ac = w_a - w_c;
    w_pa   = abs10(w_d_bc);
    w_pb   = abs10(w_d_ac);
    w_pc   = abs10(w_d_bc + w_d_ac);
    if ((w_pa <= w_pb) && (w_pa <= w_pc)) o_pred = i_a;
    else if (w_pb <= w_pc)                o_pred = i_b;
    else                                  o_pred = i_c;
  end

endmodule

// File: rtl/png_filter.sv
// PNG scanline filter: one byte per two cycles, type byte at each row start.
// Drives the single-port previous-row line fifo: read up-byte in RD, write raw byte in WR.
module png_filter
  import png_filter_pkg::*;
#(
  parameter int BPP_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start_i,
  input  logic [SIZE_W_WD-1:0] cfg_w_i,
  input  logic [SIZE_H_WD-1:0] cfg_h_i,
  input  logic [2:0]           cfg_bpp_i,
  input  logic [2:0]           cfg_typ_i,
  input  logic                 dat_val_i,
  input  logic [7:0]           dat_i,
  output logic                 dat_rdy_o,
  output logic                 fifo_rd_val_o,
  input  logic [7:0]           fifo_rd_dat_i,
  output logic                 fifo_wr_val_o,
  output logic [7:0]           fifo_wr_dat_o,
  output logic                 out_val_o,
  output logic [7:0]           out_dat_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int BPP_IW = (BPP_MAX > 1) ? $clog2(BPP_MAX) : 1;

  state_e               r_state;
  state_e               w_next;
  logic [SIZE_W_WD-1:0] r_w;
  logic [SIZE_H_WD-1:0] r_h;
  logic [BPP_IW-1:0]    r_bpp_m1;
  flt_e                 r_typ;
  logic [SIZE_W_WD-1:0] r_col;
  logic [SIZE_H_WD-1:0] r_row;
  logic [7:0]           r_x;
  logic [7:0]           r_a_hist [BPP_MAX];
  logic [7:0]           r_c_hist [BPP_MAX];

  logic                 w_left_ok;
  logic                 w_col_last;
  logic                 w_row_last;
  logic [7:0]           w_a;
  logic [7:0]           w_b;
  logic [7:0]           w_c;
  logic [7:0]           w_paeth;
  logic [7:0]           w_filt;

  // Out-of-range bytes-per-pixel values are clamped into 1..BPP_MAX and stored minus one.
  function automatic logic [BPP_IW-1:0] bpp_clamp_m1(input logic [2:0] bpp);
    int v;
    v = int'(bpp);
    if (v < 1)       v = 1;
    if (v > BPP_MAX) v = BPP_MAX;
    return BPP_IW'(v - 1);
  endfunction

  // Filtered byte, all arithmetic modulo 256; Average uses a 9-bit sum before the halving.
  function automatic logic [7:0] filt_byte(input flt_e t, input logic [7:0] x, input logic [7:0] a,
                                           input logic [7:0] b, input logic [7:0] p);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b};
    case (t)
      FLT_SUB:   r = x - a;
      FLT_UP:    r = x - b;
      FLT_AVG:   r = x - s[8:1];
      FLT_PAETH: r = x - p;
      default:   r = x;
    endcase
    return r;
  endfunction

  // Predictor selection: left/upper-left only exist once col has reached bpp; row 0 has no up-row.
  always_comb begin
    w_left_ok  = (r_col > SIZE_W_WD'(r_bpp_m1));
    w_col_last = (r_col == (r_w - SIZE_W_WD'(1)));
    w_row_last = (r_row == (r_h - SIZE_H_WD'(1)));
    w_b        = (r_row == '0) ? 8'd0 : fifo_rd_dat_i;
    w_a        = w_left_ok ? r_a_hist[r_bpp_m1] : 8'd0;
    w_c        = w_left_ok ? r_c_hist[r_bpp_m1] : 8'd0;
    w_filt     = filt_byte(r_typ, r_x, w_a, w_b, w_paeth);
  end

  png_filter_paeth u_paeth (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_c    (w_c),
    .o_pred (w_paeth)
  );

  // Next-state and output decode; everything idles at zero outside its owning state.
  always_comb begin
    w_next        = r_state;
    dat_rdy_o     = 1'b0;
    fifo_rd_val_o = 1'b0;
    fifo_wr_val_o = 1'b0;
    fifo_wr_dat_o = 8'd0;
    out_val_o     = 1'b0;
    out_dat_o     = 8'd0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_next = ST_TYPE;
      end
      ST_TYPE: begin
        busy_o    = 1'b1;
        out_val_o = 1'b1;
        out_dat_o = {5'd0, r_typ};
        w_next    = ST_RD;
      end
      ST_RD: begin
        busy_o        = 1'b1;
        dat_rdy_o     = 1'b1;
        fifo_rd_val_o = dat_val_i;
        if (dat_val_i) w_next = ST_WR;
      end
      ST_WR: begin
        busy_o        = 1'b1;
        out_val_o     = 1'b1;
        out_dat_o     = w_filt;
        fifo_wr_val_o = 1'b1;
        fifo_wr_dat_o = r_x;
        if (!w_col_last)     w_next = ST_RD;
        else if (w_row_last) w_next = ST_DONE;
        else                 w_next = ST_TYPE;
      end
      ST_DONE: begin
        done_o = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, config latch, counters and predictor history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_w      <= '0;
      r_h      <= '0;
      r_bpp_m1 <= '0;
      r_typ    <= FLT_NONE;
      r_col    <= '0;
      r_row    <= '0;
      r_x      <= 8'd0;
      for (int i = 0; i < BPP_MAX; i++) begin
        r_a_hist[i] <= 8'd0;
        r_c_hist[i] <= 8'd0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_w      <= cfg_w_i;
            r_h      <= cfg_h_i;
            r_bpp_m1 <= bpp_clamp_m1(cfg_bpp_i);
            r_typ    <= flt_decode(cfg_typ_i);
            r_col    <= '0;
            r_row    <= '0;
          end
        end
        ST_TYPE: begin
          for (int i = 0; i < BPP_MAX; i++) begin
            r_a_hist[i] <= 8'd0;
            r_c_hist[i] <= 8'd0;
          end
        end
        ST_RD: begin
          if (dat_val_i) r_x <= dat_i;
        end
        ST_WR: begin
          r_a_hist[0] <= r_x;
          r_c_hist[0] <= w_b;
          for (int i = 1; i < BPP_MAX; i++) begin
            r_a_hist[i] <= r_a_hist[i-1];
            r_c_hist[i] <= r_c_hist[i-1];
          end
          if (w_col_last) begin
            r_col <= '0;
            if (!w_row_last) r_row <= r_row + SIZE_H_WD'(1);
          end else begin
            r_col <= r_col + SIZE_W_WD'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_png_filter.sv
// Directed bench for png_filter with a behavioural line-fifo model.
module tb_png_filter;
  import png_filter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 start_i;
  logic [SIZE_W_WD-1:0] cfg_w_i;
  logic [SIZE_H_WD-1:0] cfg_h_i;
  logic [2:0]           cfg_bpp_i;
  logic [2:0]           cfg_typ_i;
  logic                 dat_val_i;
  logic [7:0]           dat_i;
  logic                 dat_rdy_o;
  logic                 fifo_rd_val_o;
  logic [7:0]           fifo_rd_dat_i;
  logic                 fifo_wr_val_o;
  logic [7:0]           fifo_wr_dat_o;
  logic                 out_val_o;
  logic [7:0]           out_dat_o;
  logic                 busy_o;
  logic                 done_o;

  png_filter #(.BPP_MAX(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .start_i       (start_i),
    .cfg_w_i       (cfg_w_i),
    .cfg_h_i       (cfg_h_i),
    .cfg_bpp_i     (cfg_bpp_i),
    .cfg_typ_i     (cfg_typ_i),
    .dat_val_i     (dat_val_i),
    .dat_i         (dat_i),
    .dat_rdy_o     (dat_rdy_o),
    .fifo_rd_val_o (fifo_rd_val_o),
    .fifo_rd_dat_i (fifo_rd_dat_i),
    .fifo_wr_val_o (fifo_wr_val_o),
    .fifo_wr_dat_o (fifo_wr_dat_o),
    .out_val_o     (out_val_o),
    .out_dat_o     (out_dat_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int in_q[$];
  int exp_q[$];
  int out_q[$];

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_out_cyc = 0;
  int coin_cnt = 0;
  int rdy_cnt = 0;
  int rdy_consec = 0;
  bit prev_rdy_val = 1'b0;

  // Line-fifo model: one row deep, read data registered, pointers wrap at row width.
  int fw = 1;
  int rptr;
  int wptr;
  logic [7:0] fmem [256];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr          <= 0;
      wptr          <= 0;
      fifo_rd_dat_i <= 8'd0;
    end else begin
      if (fifo_rd_val_o) begin
        fifo_rd_dat_i <= fmem[rptr];
        rptr          <= (rptr == fw - 1) ? 0 : rptr + 1;
      end
      if (fifo_wr_val_o) begin
        fmem[wptr] <= fifo_wr_dat_o;
        wptr       <= (wptr == fw - 1) ? 0 : wptr + 1;
      end
    end
  end

  // Output monitor on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (out_val_o) begin
      out_q.push_back(int'(out_dat_o));
      last_out_cyc = cyc;
    end
    if (done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (fifo_rd_val_o && fifo_wr_val_o) coin_cnt = coin_cnt + 1;
    if (dat_rdy_o) rdy_cnt = rdy_cnt + 1;
    if (dat_rdy_o && dat_val_i && prev_rdy_val) rdy_consec = rdy_consec + 1;
    prev_rdy_val = dat_rdy_o && dat_val_i;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " out_val"},  int'(out_val_o),     0);
    chk({tag, " out_dat"},  int'(out_dat_o),     0);
    chk({tag, " dat_rdy"},  int'(dat_rdy_o),     0);
    chk({tag, " fifo_rd"},  int'(fifo_rd_val_o), 0);
    chk({tag, " fifo_wr"},  int'(fifo_wr_val_o), 0);
    chk({tag, " fifo_dat"}, int'(fifo_wr_dat_o), 0);
    chk({tag, " busy"},     int'(busy_o),        0);
    chk({tag, " done"},     int'(done_o),        0);
  endtask

  // Feed in_q as one image with dat_val_i held high, then compare against exp_q.
  // With glitch set, a second start with different cfg is pulsed mid-image and must be ignored.
  task automatic run_image(input string tag, input int w, input int h, input int bpp,
                           input int typ, input bit glitch);
    int idx;
    int guard;
    bit acc;
    int n;
    out_q.delete();
    done_cnt = 0;
    rdy_cnt  = 0;
    fw       = w;
    @(posedge clk); #1;
    start_i   = 1'b1;
    cfg_w_i   = w[SIZE_W_WD-1:0];
    cfg_h_i   = h[SIZE_H_WD-1:0];
    cfg_bpp_i = bpp[2:0];
    cfg_typ_i = typ[2:0];
    @(posedge clk); #1;
    start_i   = 1'b0;
    idx       = 0;
    guard     = 0;
    dat_val_i = 1'b1;
    dat_i     = in_q[0][7:0];
    while (idx < in_q.size() && guard < 400) begin
      @(negedge clk);
      acc = dat_val_i && dat_rdy_o;
      @(posedge clk); #1;
      guard++;
      start_i = 1'b0;
      if (acc) begin
        idx++;
        if (glitch && idx == 1) begin
          start_i   = 1'b1;
          cfg_typ_i = 3'd0;
          cfg_w_i   = 1;
          cfg_bpp_i = 3'd2;
        end
      end
      if (idx < in_q.size()) dat_i = in_q[idx][7:0];
      else                   dat_val_i = 1'b0;
    end
    start_i   = 1'b0;
    dat_val_i = 1'b0;
    chk({tag, " fed"}, idx, in_q.size());
    guard = 0;
    while (done_cnt == 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done_cnt"}, done_cnt, 1);
    chk({tag, " done_lat"}, done_cyc, last_out_cyc + 1);
    chk({tag, " busy_end"}, int'(busy_o), 0);
    chk({tag, " n_out"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s out[%0d]", tag, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    rstn      = 1'b0;
    start_i   = 1'b0;
    cfg_w_i   = '0;
    cfg_h_i   = '0;
    cfg_bpp_i = 3'd0;
    cfg_typ_i = 3'd0;
    dat_val_i = 1'b0;
    dat_i     = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("post_reset");

    in_q = '{10, 20, 30, 40};
    exp_q = '{0, 10, 20, 30, 40};
    run_image("none", 4, 1, 1, 0, 1'b0);

    exp_q = '{1, 10, 10, 10, 10};
    run_image("sub", 4, 1, 1, 1, 1'b0);

    in_q = '{5, 7, 8, 9};
    exp_q = '{2, 5, 7, 2, 3, 2};
    run_image("up", 2, 2, 1, 2, 1'b0);
    chk("up rd_wr_overlap", coin_cnt, 0);

    in_q = '{100, 50, 10, 10};
    exp_q = '{3, 100, 0, 3, 216, 236};
    run_image("avg", 2, 2, 1, 3, 1'b1);

    in_q = '{1, 2, 3, 4};
    exp_q = '{4, 1, 1, 4, 2, 1};
    run_image("paeth", 2, 2, 1, 4, 1'b0);

    in_q = '{1, 2, 3, 4, 5, 6};
    exp_q = '{1, 1, 2, 3, 3, 3, 3};
    run_image("sub3", 6, 1, 3, 1, 1'b0);
    chk("sub3 rdy_cycles", rdy_cnt, 6);

    in_q = '{7, 9};
    exp_q = '{0, 7, 9};
    run_image("typ6", 2, 1, 1, 6, 1'b0);

    // Reset in the middle of the first row of an Up image.
    fw = 2;
    @(posedge clk); #1;
    start_i   = 1'b1;
    cfg_w_i   = 2;
    cfg_h_i   = 2;
    cfg_bpp_i = 3'd1;
    cfg_typ_i = 3'd2;
    @(posedge clk); #1;
    start_i   = 1'b0;
    dat_val_i = 1'b1;
    dat_i     = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst busy_before", int'(busy_o), 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    dat_val_i = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;

    in_q = '{5, 7, 8, 9};
    exp_q = '{2, 5, 7, 2, 3, 2};
    run_image("after_rst", 2, 2, 1, 2, 1'b0);

    chk("rd_wr_overlap_total", coin_cnt, 0);
    chk("rdy_back_to_back", rdy_consec, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
